run_ctrl: RTL

Parametrised execution controller for the pipelined MIPS core. It replaces the fixed manual/1 Hz clock selection with a single free-running clock plus a clock enable `cpu_en` to every pipeline register, the PC counter and the memories. It supports free-run, slow-run, N-cycle step and run-to-breakpoint modes, with a programmable breakpoint bank and an enabled-cycle counter. It sits between the debounced board buttons/switches and the core.

---
 rtl/run_ctrl_pkg.sv | 22 ++
 rtl/run_ctrl_bp_bank.sv | 46 ++++
 rtl/run_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the execution controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN_FAST  = 2'b00,
        MODE_RUN_SLOW  = 2'b01,
        MODE_STEP      = 2'b10,
        MODE_RUN_TO_BP = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    // Index width for a bank of n entries; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_ctrl_bp_bank.sv
// Breakpoint register bank with parallel compare and lowest-index priority.
module bp_bank #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned NUM_BP = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [PC_W-1:0]  i_addr,
    input  logic             i_en,
    input  logic [PC_W-1:0]  i_pc,
    output logic             o_match,
    output logic [IDX_W-1:0] o_match_idx
);

    logic [PC_W-1:0]   r_addr [NUM_BP];
    logic [NUM_BP-1:0] r_en;

    // Write port; an entry written this cycle is seen by the comparator next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                r_addr[i] <= '0;
            end
        end else if (i_wr && (32'(i_idx) < NUM_BP)) begin
            r_addr[i_idx] <= i_addr;
            r_en[i_idx]   <= i_en;
        end
    end

    // Compare all entries; scanning downwards leaves the lowest hit index.
    always_comb begin
        o_match     = 1'b0;
        o_match_idx = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (r_en[i] && (r_addr[i] == i_pc)) begin
                o_match     = 1'b1;
                o_match_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Execution controller: produces the core clock enable for run/slow/step/breakpoint modes.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter  int unsigned PC_W   = 16,
    parameter  int unsigned NUM_BP = 4,
    parameter  int unsigned CNT_W  = 16,
    parameter  int unsigned DIV    = 50_000_000,
    localparam int unsigned IDX_W  = idx_width(NUM_BP)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             go,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] step_count,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_wr,
    input  logic [IDX_W-1:0] bp_idx,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_en,
    output logic             cpu_en,
    output logic             running,
    output logic             bp_hit,
    output logic [IDX_W-1:0] bp_hit_idx,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state
);

    localparam int unsigned    PS_W    = $clog2(DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    state_e            r_state, r_state_nx;
    logic [PS_W-1:0]   r_presc, r_presc_nx;
    logic [CNT_W-1:0]  r_remain, r_remain_nx;
    logic              r_skip, r_skip_nx;
    logic              r_bp_hit, r_bp_hit_nx;
    logic [IDX_W-1:0]  r_bp_idx, r_bp_idx_nx;
    logic [CNT_W-1:0]  r_cycle_cnt;

    mode_e             w_mode;
    logic              w_match;
    logic [IDX_W-1:0]  w_match_idx;
    logic              w_tick;
    logic              w_cpu_en;

    bp_bank #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP),
        .IDX_W  (IDX_W)
    ) u_bp_bank (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_wr        (bp_wr),
        .i_idx       (bp_idx),
        .i_addr      (bp_addr),
        .i_en        (bp_en),
        .i_pc        (pc),
        .o_match     (w_match),
        .o_match_idx (w_match_idx)
    );

    // State, counters and sticky breakpoint status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HALT;
            r_presc     <= '0;
            r_remain    <= '0;
            r_skip      <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_bp_idx    <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= r_state_nx;
            r_presc     <= r_presc_nx;
            r_remain    <= r_remain_nx;
            r_skip      <= r_skip_nx;
            r_bp_hit    <= r_bp_hit_nx;
            r_bp_idx    <= r_bp_idx_nx;
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(w_cpu_en);
        end
    end

    // Next state and Mealy enable; halt_req outranks go, breakpoints and step completion.
    always_comb begin
        w_mode      = mode_e'(mode);
        w_tick      = (r_presc == PS_LAST);
        w_cpu_en    = 1'b0;
        r_state_nx  = r_state;
        r_presc_nx  = '0;
        r_remain_nx = r_remain;
        r_skip_nx   = r_skip;
        r_bp_hit_nx = r_bp_hit;
        r_bp_idx_nx = r_bp_idx;

        case (r_state)
            ST_HALT: begin
                if (go && !halt_req) begin
                    r_skip_nx   = 1'b1;
                    r_bp_hit_nx = 1'b0;
                    if (w_mode == MODE_STEP) begin
                        r_state_nx  = ST_STEP;
                        r_remain_nx = (step_count == '0) ? CNT_W'(1) : step_count;
                    end else begin
                        r_state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req || (w_mode == MODE_STEP)) begin
                    r_state_nx = ST_HALT;
                end else begin
                    if (w_mode == MODE_RUN_SLOW) begin
                        w_cpu_en   = w_tick;
                        r_presc_nx = w_tick ? '0 : r_presc + PS_W'(1);
                    end else begin
                        w_cpu_en = 1'b1;
                    end
                    // A hit suppresses the fetch at the breakpoint PC.
                    if ((w_mode == MODE_RUN_TO_BP) && w_match && !r_skip) begin
                        w_cpu_en    = 1'b0;
                        r_state_nx  = ST_HALT;
                        r_bp_hit_nx = 1'b1;
                        r_bp_idx_nx = w_match_idx;
                    end
                end
            end
            ST_STEP: begin
                if (halt_req) begin
                    r_state_nx = ST_HALT;
                end else begin
                    w_cpu_en    = 1'b1;
                    r_remain_nx = r_remain - CNT_W'(1);
                    if (r_remain <= CNT_W'(1)) begin
                        r_state_nx = ST_HALT;
                    end
                end
            end
            default: r_state_nx = ST_HALT;
        endcase

        // The first enabled cycle after go consumes the skip.
        if (w_cpu_en) begin
            r_skip_nx = 1'b0;
        end
    end

    assign cpu_en     = w_cpu_en;
    assign running    = (r_state != ST_HALT);
    assign bp_hit     = r_bp_hit;
    assign bp_hit_idx = r_bp_idx;
    assign cycle_cnt  = r_cycle_cnt;
    assign state      = r_state;

endmodule
